mips_inst_encoder: RTL and testbench
====================================

Name: mips_inst_encoder

Overview:
Encoder counterpart to the pipeline's ID-stage instruction decoder. It accepts symbolic instructions (an instruction selector plus register, shift, immediate and target fields) over a valid/ready handshake. It packs each one into a 32-bit MIPS word using the same opcode/funct map the decoder recognises, including the custom hamd R-type. Encoded words are written sequentially into instruction memory, which lets the bench and boot loader build programs without hand-assembled hex.

Parameters:
ADDR_W, 6, IMEM word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first IMEM word address written after reset/clear

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction request valid
in_ready  out  1  encoder can accept this cycle
in_sel  in  5  selector: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 jr,9 hamd,10 addi,11 andi,12 ori,13 xori,14 lw,15 sw,16 beq,17 bne,18 lui,19 j,20 jal; 21-31 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_sa  in  5  shift amount
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
in_last  in  1  marks final instruction of program
clear  in  1  return from DONE to IDLE, address reset
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  IMEM write address
imem_wdata  out  32  encoded instruction
done  out  1  program complete or memory full
full  out  1  capacity exhausted
err_illegal  out  1  sticky, illegal selector seen
inst_count  out  ADDR_W+1  words written since reset/clear

Behaviour:
- Reset (sync, rst=1): state IDLE; all outputs 0 except in_ready=1; write pointer=BASE_ADDR. Reset mid-operation discards any pending write; imem_we is 0 in the following cycle.
- Accept = in_valid & in_ready. An accepted legal instruction produces imem_we=1 exactly one cycle later, carrying imem_addr=pointer and imem_wdata=encoding. The pointer and inst_count increment in that same cycle. Throughput is one word per cycle.
- R-type word: {6'b0, rs, rt, rd, sa, funct}. funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000, hamd 110000.
- sll/srl/sra: rs field forced to 0; sa taken from in_sa. All other R-types force sa to 0.
- jr: rt, rd and sa forced to 0.
- I-type word: {op, rs, rt, imm}. op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111. lui forces rs to 0.
- J-type word: {op, target}. op: j 000010, jal 000011.
- Illegal selector: the request is consumed (handshake completes), nothing is written, the pointer is unchanged, and err_illegal is set. err_illegal stays set until rst or clear.
- FSM:
  - IDLE: first accept -> RUN (or DONE if in_last).
  - RUN: accept with in_last -> DONE.
  - RUN: a write to the last address (BASE_ADDR+2^ADDR_W-1 modulo wrap) -> DONE with full=1. in_ready drops in the cycle of that accept, so no further request is taken.
  - DONE: in_ready=0, done=1. clear -> IDLE, pointer=BASE_ADDR, inst_count=0, full=0, err_illegal=0.
- in_last on an illegal selector still moves the FSM to DONE.
- The pointer wraps modulo 2^ADDR_W; the full condition prevents overwriting.
- clear outside DONE is ignored. rst takes priority over clear.
- in_ready is combinational from state and the full look-ahead only, never from in_valid.

Optional Feature:
INST_ENC_HAMD_EN
- Defined: selector 9 encodes hamd (funct 110000).
- Undefined: selector 9 is treated as illegal (sets err_illegal, no write), which matches decoders built without the hamd ALU path.

Test Plan:
- rst, then add rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0, wdata=0x00221820, inst_count=1.
- Back-to-back lw rs=4 rt=5 imm=8, sll rt=3 rd=2 sa=4 with in_rs=7 -> wdata 0x8C850008 at addr 0, then 0x00031100 at addr 1 (rs masked); in_ready held 1 throughout.
- jal target=0x10 with in_last -> wdata 0x0C000010; done=1 and in_ready=0 next cycle; clear -> IDLE, inst_count=0, next write lands at addr 0.
- hamd rs=1 rt=2 rd=4: with INST_ENC_HAMD_EN -> 0x00222030 written; without -> no write, err_illegal=1, pointer unchanged.
- ADDR_W=2, five valid requests -> four writes (addr 0..3), full=1, done=1, in_ready=0 after the fourth accept; the fifth request is never accepted.
- Selector 25 then add -> no write for the first, err_illegal=1; add written at addr 0. Assert rst mid-stream -> imem_we=0 the next cycle and all counters zero.

Source files
------------

// File: rtl/mips_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_inst_encoder
//  Description : Packs symbolic MIPS instructions (selector + fields) into
//                32-bit words and writes them sequentially into instruction
//                memory. Accepts one request per cycle over valid/ready.
//                Build option INST_ENC_HAMD_EN enables the custom hamd R-type
//                (selector 9); without it selector 9 is rejected as illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_inst_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_sel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   inst_count
);

  // --------------------------------------------------------------------------
  // Address constants. The last usable address is the one just before the
  // base, modulo the memory size, so a full sweep wraps exactly once.
  // --------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = FIRST_ADDR - PTR_ONE;
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

  // Instruction selectors
  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SUB  = 5'd1;
  localparam logic [4:0] SEL_AND  = 5'd2;
  localparam logic [4:0] SEL_OR   = 5'd3;
  localparam logic [4:0] SEL_XOR  = 5'd4;
  localparam logic [4:0] SEL_SLL  = 5'd5;
  localparam logic [4:0] SEL_SRL  = 5'd6;
  localparam logic [4:0] SEL_SRA  = 5'd7;
  localparam logic [4:0] SEL_JR   = 5'd8;
  localparam logic [4:0] SEL_HAMD = 5'd9;
  localparam logic [4:0] SEL_ADDI = 5'd10;
  localparam logic [4:0] SEL_ANDI = 5'd11;
  localparam logic [4:0] SEL_ORI  = 5'd12;
  localparam logic [4:0] SEL_XORI = 5'd13;
  localparam logic [4:0] SEL_LW   = 5'd14;
  localparam logic [4:0] SEL_SW   = 5'd15;
  localparam logic [4:0] SEL_BEQ  = 5'd16;
  localparam logic [4:0] SEL_BNE  = 5'd17;
  localparam logic [4:0] SEL_LUI  = 5'd18;
  localparam logic [4:0] SEL_J    = 5'd19;
  localparam logic [4:0] SEL_JAL  = 5'd20;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
`ifdef INST_ENC_HAMD_EN
  localparam logic [5:0] FN_HAMD = 6'b110000;
`endif

  // I/J-type opcodes
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              write_go;
  logic              hit_last_addr;

  // --------------------------------------------------------------------------
  // Word packing helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Combinational encoder: selector to packed word plus legality flag
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_sel)
      SEL_ADD:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
      SEL_SUB:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
      SEL_AND:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_AND);
      SEL_OR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_OR);
      SEL_XOR:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_XOR);
      // Shifts take their operand from rt; rs is not part of the encoding
      SEL_SLL:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, FN_SLL);
      SEL_SRL:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, FN_SRL);
      SEL_SRA:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, FN_SRA);
      SEL_JR:   enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      SEL_HAMD: begin
`ifdef INST_ENC_HAMD_EN
        enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_HAMD);
`else
        // Decoder without the hamd ALU path: reject like any unknown selector
        enc_legal = 1'b0;
`endif
      end
      SEL_ADDI: enc_word = i_word(OP_ADDI, in_rs, in_rt, in_imm);
      SEL_ANDI: enc_word = i_word(OP_ANDI, in_rs, in_rt, in_imm);
      SEL_ORI:  enc_word = i_word(OP_ORI,  in_rs, in_rt, in_imm);
      SEL_XORI: enc_word = i_word(OP_XORI, in_rs, in_rt, in_imm);
      SEL_LW:   enc_word = i_word(OP_LW,   in_rs, in_rt, in_imm);
      SEL_SW:   enc_word = i_word(OP_SW,   in_rs, in_rt, in_imm);
      SEL_BEQ:  enc_word = i_word(OP_BEQ,  in_rs, in_rt, in_imm);
      SEL_BNE:  enc_word = i_word(OP_BNE,  in_rs, in_rt, in_imm);
      SEL_LUI:  enc_word = i_word(OP_LUI,  5'd0,  in_rt, in_imm);
      SEL_J:    enc_word = j_word(OP_J,   in_target);
      SEL_JAL:  enc_word = j_word(OP_JAL, in_target);
      default:  enc_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake. Readiness depends only on registered state, so a producer may
  // legally wait for in_ready before raising in_valid.
  // --------------------------------------------------------------------------
  assign in_ready      = (state != S_DONE) && !full;
  assign accept        = in_valid && in_ready;
  assign write_go      = accept && enc_legal;
  // This write fills the final free slot; stop accepting from the next cycle.
  assign hit_last_addr = write_go && (ptr == LAST_ADDR);
  assign done          = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a program ends on in_last or when memory fills up
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (accept) begin
          if (in_last || hit_last_addr) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (clear) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port, pointer, counters and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      ptr         <= FIRST_ADDR;
      inst_count  <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      imem_we <= write_go;
      if (write_go) begin
        imem_addr  <= ptr;
        imem_wdata <= enc_word;
        ptr        <= ptr + PTR_ONE;
        inst_count <= inst_count + CNT_ONE;
      end
      if (hit_last_addr) begin
        full <= 1'b1;
      end
      if (accept && !enc_legal) begin
        err_illegal <= 1'b1;
      end
      // No request is accepted in DONE, so clear never collides with a write
      if (done && clear) begin
        ptr         <= FIRST_ADDR;
        inst_count  <= '0;
        full        <= 1'b0;
        err_illegal <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_inst_encoder
//  Description : Scoreboard bench for mips_inst_encoder with directed
//                instructions followed by a randomized stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_inst_encoder;

  localparam int ADDR_W    = 3;
  localparam int BASE_ADDR = 5;
  localparam int DEPTH     = 1 << ADDR_W;

`ifdef INST_ENC_HAMD_EN
  localparam bit HAMD_ON = 1'b1;
`else
  localparam bit HAMD_ON = 1'b0;
`endif

  // funct per R-type selector 0..9, opcode per selector 10..20
  localparam int FUNCT_TBL [10] = '{32, 34, 36, 37, 38, 0, 2, 3, 8, 48};
  localparam int OPC_TBL   [11] = '{8, 12, 13, 14, 35, 43, 4, 5, 15, 2, 3};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_sel = '0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_sa = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;
  logic              clear = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              done;
  logic              full;
  logic              err_illegal;
  logic [ADDR_W:0]   inst_count;

  mips_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .clear(clear),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .full(full), .err_illegal(err_illegal), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int m_n    = 0;
  bit m_done = 1'b0;
  bit m_full = 1'b0;
  bit m_err  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Instruction word from field values using shift-by-multiplication
  function automatic bit ref_encode(input int sel, input int rs, input int rt, input int rd,
                                    input int sa, input int imm, input int tgt,
                                    output logic [31:0] w);
    longint v;
    bit     shift;
    bit     jr;
    w = 32'd0;
    if (sel < 10) begin
      if (sel == 9 && !HAMD_ON) return 1'b0;
      shift = (sel >= 5 && sel <= 7);
      jr    = (sel == 8);
      v = longint'(FUNCT_TBL[sel])
        + longint'(shift ? sa : 0) * 64
        + longint'(jr ? 0 : rd) * 2048
        + longint'(jr ? 0 : rt) * 65536
        + longint'(shift ? 0 : rs) * 2097152;
    end else if (sel <= 18) begin
      v = longint'(OPC_TBL[sel-10]) * 67108864
        + longint'(sel == 18 ? 0 : rs) * 2097152
        + longint'(rt) * 65536
        + longint'(imm);
    end else if (sel <= 20) begin
      v = longint'(OPC_TBL[sel-10]) * 67108864 + longint'(tgt);
    end else begin
      return 1'b0;
    end
    w = v[31:0];
    return 1'b1;
  endfunction

  // One cycle: check status against the model, then drive and predict
  task automatic drive(input bit v, input int sel, input int rs, input int rt, input int rd,
                       input int sa, input int imm, input int tgt, input bit last,
                       input bit clr, input bit rst_i, input bit use_lit,
                       input logic [31:0] lit);
    logic [31:0] w;
    bit          legal;
    @(negedge clk);
    chk("in_ready", longint'(in_ready), longint'(!m_done));
    chk("done", longint'(done), longint'(m_done));
    chk("full", longint'(full), longint'(m_full));
    chk("err_illegal", longint'(err_illegal), longint'(m_err));
    chk("inst_count", longint'(inst_count), longint'(m_n));
    rst       = rst_i;
    clear     = clr;
    in_valid  = v;
    in_sel    = 5'(sel);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_sa     = 5'(sa);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    in_last   = last;
    if (rst_i) begin
      m_n = 0; m_done = 0; m_full = 0; m_err = 0;
    end else if (m_done) begin
      if (clr) begin
        m_n = 0; m_done = 0; m_full = 0; m_err = 0;
      end
    end else if (v) begin
      legal = ref_encode(sel, rs & 31, rt & 31, rd & 31, sa & 31, imm & 65535,
                         tgt & 67108863, w);
      if (legal) begin
        if (use_lit) w = lit;
        exp_q.push_back('{(BASE_ADDR + m_n) % DEPTH, w});
        m_n++;
        if (m_n == DEPTH) begin
          m_full = 1; m_done = 1;
        end
      end else begin
        m_err = 1;
      end
      if (last) m_done = 1;
    end
  endtask

  task automatic req(input int sel, input int rs, input int rt, input int rd, input int sa,
                     input int imm, input int tgt, input bit last);
    drive(1, sel, rs, rt, rd, sa, imm, tgt, last, 0, 0, 0, 32'd0);
  endtask

  task automatic req_lit(input int sel, input int rs, input int rt, input int rd, input int sa,
                         input int imm, input int tgt, input bit last, input logic [31:0] lit);
    drive(1, sel, rs, rt, rd, sa, imm, tgt, last, 0, 0, 1, lit);
  endtask

  task automatic idle(input bit clr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, 0, 0, 32'd0);
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %0h data %08h expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", longint'(imem_addr), longint'(e.addr));
          chk("imem_wdata", longint'(imem_wdata), longint'(e.data));
        end
      end
    end
  end

  initial begin
    int sel;
    bit clr;
    bit rs_i;
    repeat (2) @(negedge clk);

    // Directed instructions with hand-assembled expected words
    req_lit(0, 1, 2, 3, 0, 0, 0, 0, 32'h00221820);              // add
    req_lit(14, 4, 5, 0, 0, 8, 0, 0, 32'h8C850008);             // lw
    req_lit(5, 7, 3, 2, 4, 0, 0, 0, 32'h00031100);              // sll, rs masked
    req_lit(20, 0, 0, 0, 0, 0, 32'h10, 1, 32'h0C000010);        // jal, last
    idle(0);
    req(0, 1, 1, 1, 0, 0, 0, 0);                                // refused while done
    idle(1);                                                    // clear
    req_lit(9, 1, 2, 4, 0, 0, 0, 0, 32'h00222030);              // hamd
    req(25, 3, 3, 3, 3, 3, 3, 0);                               // illegal
    req_lit(0, 1, 2, 3, 0, 0, 0, 0, 32'h00221820);
    idle(1);                                                    // clear ignored in RUN
    req(31, 0, 0, 0, 0, 0, 0, 1);                               // illegal with last
    idle(0);
    idle(1);

    // Fill memory: DEPTH writes, then one more request that must be refused
    for (int i = 0; i <= DEPTH; i++) begin
      sel = (i % 2 == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 8));
      req(sel, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
          int'($urandom), int'($urandom), 0);
    end
    idle(0);
    idle(1);

    // Mid-stream reset
    req(1, 4, 5, 6, 0, 0, 0, 0);
    drive(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 32'd0);
    idle(0);

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      clr  = m_done ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rs_i = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            $urandom_range(0, 15) == 0, clr, rs_i, 0, 32'd0);
    end
    idle(0);
    idle(0);
    idle(0);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
